mem_checker: RTL and testbench

Self-contained memory test master for the `membus` memory interface. On a start request it fills every location of an attached `mem` slave with a seeded pattern, reads every location back and compares each word against the expected value. It reports pass/fail, an error count and the first failing address. It sits on the master side of `membus`, in place of a free-running write-only tester, and checks the read path that the write-only tester never exercises.

---
 rtl/mem_checker_if.sv | 25 ++
 rtl/mem_checker.sv | 135 +++++++++++++
 tb/tb_mem_checker.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_checker_if.sv
// Memory bus between the checker (master) and a single-port memory (slave).
// The slave returns read data one cycle after the address is presented.
interface mem_checker_if #(
    parameter int LEN = 256,
    parameter int DW  = 8
) ();
    logic [$clog2(LEN)-1:0] addr;
    logic [DW-1:0]          d;
    logic                   wr;
    logic [DW-1:0]          q;

    modport master (
        output addr,
        output d,
        output wr,
        input  q
    );

    modport slave (
        input  addr,
        input  d,
        input  wr,
        output q
    );
endinterface

// File: rtl/mem_checker.sv
// Memory test master: fills every word with (address ^ seed), reads every
// word back one cycle behind the issued address, and reports pass/fail,
// mismatch count and the first failing address.
module mem_checker #(
    parameter int LEN = 256,
    parameter int DW  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DW-1:0]          seed,
    mem_checker_if.master          bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [$clog2(LEN):0]   err_cnt,
    output logic [$clog2(LEN)-1:0] first_err_addr
);
    localparam int AW = $clog2(LEN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [AW-1:0] ADDR_LAST = AW'(LEN - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   ERR_ONE   = (AW + 1)'(1);

    logic [2:0]    state;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] seed_q;
    logic          tag_valid;
    logic [AW-1:0] tag_addr;
    logic [DW-1:0] expect_data;
    logic          mismatch;

    // The address is zero-extended or truncated to the data width before the XOR.
    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic [DW-1:0] s);
        return DW'(a) ^ s;
    endfunction

    // Bus outputs, status flags and the read-back comparison are decoded from the phase.
    always_comb begin
        bus.addr    = addr_q;
        bus.wr      = (state == S_WRITE);
        bus.d       = (state == S_WRITE) ? pattern(addr_q, seed_q) : '0;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        expect_data = pattern(tag_addr, seed_q);
        mismatch    = tag_valid && (bus.q != expect_data);
    end

    // Phase sequencing and address counter; phase ends are detected at LEN-1 so any LEN works.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            addr_q <= '0;
            seed_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    addr_q <= '0;
                    if (start) begin
                        seed_q <= seed;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (addr_q == ADDR_LAST) begin
                        addr_q <= '0;
                        state  <= S_READ;
                    end else begin
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                S_READ: begin
                    if (addr_q == ADDR_LAST) begin
                        addr_q <= '0;
                        state  <= S_DRAIN;
                    end else begin
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                S_DRAIN: begin
                    addr_q <= '0;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    addr_q <= '0;
                    state  <= S_IDLE;
                end
                default: begin
                    addr_q <= '0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Compare tag follows each read address by one cycle to line up with the slave's data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_valid <= 1'b0;
            tag_addr  <= '0;
        end else begin
            tag_valid <= (state == S_READ);
            tag_addr  <= addr_q;
        end
    end

    // Result registers: cleared on acceptance, accumulated during compares, verdict set in DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else begin
            if (mismatch) begin
                err_cnt <= err_cnt + ERR_ONE;
                if (err_cnt == '0) begin
                    first_err_addr <= tag_addr;
                end
            end
            if (state == S_DRAIN) begin
                pass <= (err_cnt == '0) && !mismatch;
            end
        end
    end
endmodule

// File: tb/tb_mem_checker.sv
// Bench for mem_checker: a 64x8 instance checked every cycle against a
// run-timeline model, plus a 48x4 instance exercising non-power-of-2 LEN.
module tb_mem_checker;
    localparam int LEN  = 64;
    localparam int DW   = 8;
    localparam int LEN2 = 48;
    localparam int DW2  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [DW-1:0] seed;
    logic          busy, done, pass;
    logic [6:0]    err_cnt;
    logic [5:0]    first_err_addr;

    logic           start2;
    logic [DW2-1:0] seed2;
    logic           busy2, done2, pass2;
    logic [6:0]     err_cnt2;
    logic [5:0]     first_err_addr2;

    int total = 0;
    int bad   = 0;

    mem_checker_if #(.LEN(LEN),  .DW(DW))  bus  ();
    mem_checker_if #(.LEN(LEN2), .DW(DW2)) bus2 ();

    mem_checker #(.LEN(LEN), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .bus(bus),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr)
    );

    mem_checker #(.LEN(LEN2), .DW(DW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2), .bus(bus2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .first_err_addr(first_err_addr2)
    );

    // Memory slaves with one-cycle registered read; corrupt[] flips bit 0 on read.
    logic [DW-1:0]  mem  [LEN];
    logic [DW2-1:0] mem2 [LEN2];
    bit             corrupt [LEN];

    always @(posedge clk) begin
        if (bus.wr) mem[bus.addr] <= bus.d;
        bus.q <= mem[bus.addr] ^ {7'b0, corrupt[bus.addr]};
    end

    always @(posedge clk) begin
        if (bus2.wr) mem2[bus2.addr] <= bus2.d;
        bus2.q <= mem2[bus2.addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nCorrupt();
        int n = 0;
        for (int i = 0; i < LEN; i++) if (corrupt[i]) n++;
        return n;
    endfunction

    function automatic int firstCorrupt();
        for (int i = 0; i < LEN; i++) if (corrupt[i]) return i;
        return 0;
    endfunction

    // Run-timeline model: m_k counts cycles since acceptance (1 = first write cycle).
    bit            m_on = 1'b0;
    bit            m_run = 1'b0;
    int            m_k = 0;
    logic [DW-1:0] m_seed = '0;
    int            m_err = 0, m_first = 0, f_err = 0, f_first = 0;
    bit            m_pass = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on <= 1'b1; m_run <= 1'b0; m_err <= 0; m_first <= 0; m_pass <= 1'b0;
        end else if (!m_run) begin
            if (start) begin
                m_run <= 1'b1; m_k <= 1; m_seed <= seed;
                m_err <= 0; m_first <= 0; m_pass <= 1'b0;
                f_err <= nCorrupt(); f_first <= firstCorrupt();
            end
        end else if (m_k == 2 * LEN + 1) begin
            m_k <= m_k + 1; m_err <= f_err; m_first <= f_first; m_pass <= (f_err == 0);
        end else if (m_k == 2 * LEN + 2) begin
            m_run <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // Single compare process: checks every output against the model each cycle.
    always @(negedge clk) begin
        logic [DW-1:0] ed;
        if (m_on) begin
            if (m_run) begin
                checkOutput("busy_run", busy, 1);
                if (m_k <= LEN) begin
                    ed = DW'(m_k - 1) ^ m_seed;
                    checkOutput("wr_write", bus.wr, 1);
                    checkOutput("addr_write", bus.addr, m_k - 1);
                    checkOutput("d_write", bus.d, ed);
                end else if (m_k <= 2 * LEN) begin
                    checkOutput("wr_read", bus.wr, 0);
                    checkOutput("addr_read", bus.addr, m_k - LEN - 1);
                    checkOutput("d_read", bus.d, 0);
                end else begin
                    checkOutput("wr_tail", bus.wr, 0);
                    checkOutput("addr_tail", bus.addr, 0);
                end
                checkOutput("done_run", done, (m_k == 2 * LEN + 2));
                if (m_k == 2 * LEN + 2) begin
                    checkOutput("pass_done", pass, m_pass);
                    checkOutput("err_done", err_cnt, m_err);
                    checkOutput("first_done", first_err_addr, m_first);
                end else begin
                    checkOutput("pass_run", pass, 0);
                end
            end else begin
                checkOutput("busy_idle", busy, 0);
                checkOutput("done_idle", done, 0);
                checkOutput("wr_idle", bus.wr, 0);
                checkOutput("addr_idle", bus.addr, 0);
                checkOutput("d_idle", bus.d, 0);
                checkOutput("pass_idle", pass, m_pass);
                checkOutput("err_idle", err_cnt, m_err);
                checkOutput("first_idle", first_err_addr, m_first);
            end
        end
    end

    // Small-instance monitor: write count and highest address per phase.
    int wr2Cnt = 0, wr2Max = 0, rd2Max = 0;
    always @(negedge clk) begin
        if (busy2 && bus2.wr) begin
            wr2Cnt++;
            if (int'(bus2.addr) > wr2Max) wr2Max = int'(bus2.addr);
        end else if (busy2 && int'(bus2.addr) > rd2Max) begin
            rd2Max = int'(bus2.addr);
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; seed = '0; seed2 = '0;
        for (int i = 0; i < LEN; i++) corrupt[i] = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pass", pass, 0);
        checkOutput("reset_err", err_cnt, 0);
        checkOutput("reset_busy2", busy2, 0);
        rst_n = 1'b1;

        $display("[TB] basic run seed A5");
        applyStimulus(8'hA5);
        waitDone(cyc);
        checkOutput("latency_a5", cyc, 130);
        checkOutput("pass_a5", pass, 1);
        checkOutput("err_a5", err_cnt, 0);
        checkOutput("mem_a5_7", mem[7], 8'hA2);

        $display("[TB] single corruption at 5");
        corrupt[5] = 1'b1;
        applyStimulus(8'hA5);
        waitDone(cyc);
        checkOutput("pass_c5", pass, 0);
        checkOutput("err_c5", err_cnt, 1);
        checkOutput("first_c5", first_err_addr, 5);
        corrupt[5] = 1'b0;

        $display("[TB] corruption at 10, 3, 63");
        corrupt[10] = 1'b1; corrupt[3] = 1'b1; corrupt[63] = 1'b1;
        applyStimulus(8'hA5);
        waitDone(cyc);
        checkOutput("err_c3", err_cnt, 3);
        checkOutput("first_c3", first_err_addr, 3);
        checkOutput("pass_c3", pass, 0);
        for (int i = 0; i < LEN; i++) corrupt[i] = 1'b0;

        $display("[TB] start held high");
        @(negedge clk);
        seed = 8'h3C; start = 1'b1;
        @(negedge clk);
        waitDone(cyc);
        checkOutput("latency_held", cyc, 130);
        @(negedge clk);
        checkOutput("held_idle_gap", busy, 0);
        @(negedge clk);
        checkOutput("held_rearm", busy, 1);
        start = 1'b0;
        waitDone(cyc);
        checkOutput("latency_held2", cyc, 130);

        $display("[TB] extra pulse mid-read");
        applyStimulus(8'h5A);
        repeat (LEN + 10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(cyc);
        checkOutput("latency_pulse", cyc, LEN - 9);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pulse_no_rerun", busy, 0);

        $display("[TB] reset at read address 20");
        applyStimulus(8'h77);
        cyc = 0;
        while (!(busy && !bus.wr && bus.addr == 6'd20) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reach_addr20", bus.addr, 20);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_addr", bus.addr, 0);
        checkOutput("abort_err", err_cnt, 0);
        repeat (4) @(negedge clk);
        applyStimulus(8'h77);
        waitDone(cyc);
        checkOutput("pass_after_abort", pass, 1);

        $display("[TB] back-to-back seeds 00 and FF");
        applyStimulus(8'h00);
        waitDone(cyc);
        checkOutput("pass_00", pass, 1);
        applyStimulus(8'hFF);
        waitDone(cyc);
        checkOutput("pass_ff", pass, 1);
        for (int a = 0; a < LEN; a++) begin
            logic [DW-1:0] na;
            na = ~DW'(a);
            checkOutput("mem_ff", mem[a], na);
        end

        $display("[TB] randomized runs");
        repeat (6) begin
            for (int i = 0; i < LEN; i++) corrupt[i] = ($urandom_range(0, 15) == 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(DW'($urandom));
            waitDone(cyc);
            checkOutput("latency_rand", cyc, 130);
        end
        for (int i = 0; i < LEN; i++) corrupt[i] = 1'b0;

        $display("[TB] LEN=48 DW=4 seed 3");
        wr2Cnt = 0; wr2Max = 0; rd2Max = 0;
        @(negedge clk);
        seed2 = 4'h3; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("latency_48", cyc, 98);
        checkOutput("pass_48", pass2, 1);
        checkOutput("err_48", err_cnt2, 0);
        checkOutput("first_48", first_err_addr2, 0);
        checkOutput("wrcnt_48", wr2Cnt, 48);
        checkOutput("wrmax_48", wr2Max, 47);
        checkOutput("rdmax_48", rd2Max, 47);
        for (int a = 0; a < LEN2; a++) begin
            logic [DW2-1:0] e2;
            e2 = DW2'(a) ^ 4'h3;
            checkOutput("mem_48", mem2[a], e2);
        end
        @(negedge clk);
        checkOutput("busy2_idle", busy2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
